// File: rtl/intersection_phase_sched_if.sv
// ============================================================================
// Module   : intersection_phase_sched_if
// Purpose  : Request/signal-head bundle between sensors and the phase scheduler
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface intersection_phase_sched_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req;
`ifdef PREEMPT_EN
  logic              preempt;
`endif
  logic [2*NREQ-1:0] sig;
  logic [NREQ-1:0]   active;
  logic              busy;

`ifdef PREEMPT_EN
  modport master (input req, input preempt, output sig, output active, output busy);
  modport slave  (output req, output preempt, input sig, input active, input busy);
`else
  modport master (input req, output sig, output active, output busy);
  modport slave  (output req, input sig, input active, input busy);
`endif
endinterface

`default_nettype wire

// File: rtl/intersection_phase_sched.sv
// ============================================================================
// Module   : intersection_phase_sched
// Purpose  : Round-robin GREEN/YELLOW/ALLRED phase scheduler; optional
//            emergency preemption enabled by defining PREEMPT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intersection_phase_sched #(
  parameter int NREQ          = 4,
  parameter int MIN_G         = 4,
  parameter int MAX_G         = 12,
  parameter int Y_T           = 3,
  parameter int R_T           = 2,
  parameter int CW            = 4,
  parameter int PREEMPT_PHASE = 0
) (
  input  wire logic                  clock,
  input  wire logic                  clear,
  intersection_phase_sched_if.master bus
);

  localparam int c_lw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0]   c_min   = CW'(MIN_G);
  localparam logic [CW-1:0]   c_max   = CW'(MAX_G);
  localparam logic [CW-1:0]   c_yt    = CW'(Y_T);
  localparam logic [CW-1:0]   c_rt    = CW'(R_T);
  localparam logic [CW-1:0]   c_t1    = CW'(1);
  localparam logic [NREQ-1:0] c_one   = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [1:0]      c_red   = 2'd0;
  localparam logic [1:0]      c_yel   = 2'd1;
  localparam logic [1:0]      c_grn   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     timer_q, timer_d;
  logic [NREQ-1:0]   pending_q, pending_d;
  logic [c_lw-1:0]   last_q, last_d;
  logic [2*NREQ-1:0] sig_q, sig_d;
  logic [NREQ-1:0]   active_q, active_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   w_cand;
  logic [NREQ-1:0]   w_others;
  logic [c_lw-1:0]   w_win;
  logic              w_win_ok;
  logic              w_grant;
  logic              w_preempt;
  logic              w_pp_match;
  logic              w_hold_pp;
  logic              w_force_y;

  // Without PREEMPT_EN the tie-off folds every preemption term to constant 0.
`ifdef PREEMPT_EN
  assign w_preempt = bus.preempt;
`else
  assign w_preempt = 1'b0;
`endif

  assign w_pp_match = (last_q == c_lw'(PREEMPT_PHASE));
  assign w_hold_pp  = w_preempt & w_pp_match;
  assign w_force_y  = w_preempt & ~w_pp_match;
  assign w_others   = pending_q & ~(c_one << last_q);

  // Rotating priority search starting just after the last granted phase.
  always_comb begin
    w_cand   = pending_q | bus.req;
    w_win_ok = 1'b0;
    w_win    = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_win_ok && w_cand[c_lw'((int'(last_q) + k) % NREQ)]) begin
        w_win_ok = 1'b1;
        w_win    = c_lw'((int'(last_q) + k) % NREQ);
      end
    end
    if (w_preempt) begin
      w_win_ok = 1'b1;
      w_win    = c_lw'(PREEMPT_PHASE);
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_d    = last_q;
    w_grant   = 1'b0;
    pending_d = pending_q | bus.req;
    if (state_q == S_GREEN) pending_d[last_q] = 1'b0;

    case (state_q)
      S_IDLE: w_grant = w_win_ok;
      S_GREEN: begin
        timer_d = (timer_q == c_max) ? c_max : timer_q + 1'b1;
        if (w_force_y || (!w_hold_pp && timer_q >= c_min && w_others != '0 &&
            (!bus.req[last_q] || timer_q == c_max))) begin
          state_d = S_YELLOW;
          timer_d = c_t1;
        end
      end
      S_YELLOW: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == c_yt) begin
          state_d = S_ALLRED;
          timer_d = c_t1;
        end
      end
      S_ALLRED: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == c_rt) begin
          w_grant = w_win_ok;
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_grant) begin
      state_d          = S_GREEN;
      timer_d          = c_t1;
      last_d           = w_win;
      pending_d[w_win] = 1'b0;
    end

    // Outputs are derived from the next state so they register with it.
    active_d = '0;
    sig_d    = '0;
    if (state_d == S_GREEN || state_d == S_YELLOW) active_d = c_one << last_d;
    for (int i = 0; i < NREQ; i++) begin
      sig_d[2*i +: 2] = !active_d[i] ? c_red : ((state_d == S_GREEN) ? c_grn : c_yel);
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      last_q    <= c_lw'(NREQ - 1);
      sig_q     <= '0;
      active_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      sig_q     <= sig_d;
      active_q  <= active_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sig    = sig_q;
  assign bus.active = active_q;
  assign bus.busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_intersection_phase_sched.sv
// ============================================================================
// Module   : tb_intersection_phase_sched
// Purpose  : Directed vector bench for the intersection phase scheduler
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_intersection_phase_sched;
  localparam int N = 4;
  localparam int COL_ALLRED = 0;
  localparam int COL_YEL    = 1;
  localparam int COL_GRN    = 2;
  localparam int COL_IDLE   = 3;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  intersection_phase_sched_if #(.NREQ(N)) bus ();

  intersection_phase_sched #(
    .NREQ(N), .MIN_G(4), .MAX_G(12), .Y_T(3), .R_T(2), .CW(4), .PREEMPT_PHASE(0)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           clr;
    logic [N-1:0]   req;
    logic [2*N-1:0] sig;
    logic [N-1:0]   act;
    logic           busy;
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [2*N-1:0] es,
                       input logic [N-1:0] ea, input logic eb);
    checks++;
    if (bus.sig !== es || bus.active !== ea || bus.busy !== eb) begin
      errors++;
      $display("FAIL %s: got sig=%h active=%b busy=%b, expected sig=%h active=%b busy=%b",
               name, bus.sig, bus.active, bus.busy, es, ea, eb);
    end
  endtask

  // Advance n cycles, each expected to show phase ph in colour col.
  task automatic expect_run(input string name, input int ph, input int col, input int n);
    logic [2*N-1:0] es;
    logic [N-1:0]   ea;
    logic           eb;
    for (int i = 0; i < n; i++) begin
      step();
      es = '0;
      ea = '0;
      eb = 1'b1;
      if (col == COL_GRN || col == COL_YEL) begin
        es[2*ph +: 2] = 2'(col);
        ea[ph]        = 1'b1;
      end else if (col == COL_IDLE) begin
        eb = 1'b0;
      end
      check($sformatf("%s[%0d]", name, i), es, ea, eb);
    end
  endtask

  initial begin
    clear   = 1'b1;
    bus.req = '0;
`ifdef PREEMPT_EN
    bus.preempt = 1'b0;
`endif

    //           clr   req      sig     act      busy
    tbl[0] = '{1'b1, 4'b1111, 8'h00, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 4'b1111, 8'h00, 4'b0000, 1'b0};
    tbl[2] = '{1'b0, 4'b1111, 8'h02, 4'b0001, 1'b1};
    tbl[3] = '{1'b1, 4'b0000, 8'h00, 4'b0000, 1'b0};
    tbl[4] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0};
    tbl[5] = '{1'b0, 4'b0010, 8'h08, 4'b0010, 1'b1};
    tbl[6] = '{1'b0, 4'b0000, 8'h08, 4'b0010, 1'b1};

    for (int i = 0; i < 7; i++) begin
      clear   = tbl[i].clr;
      bus.req = tbl[i].req;
      step();
      check($sformatf("vec%0d", i), tbl[i].sig, tbl[i].act, tbl[i].busy);
    end

    // Uncontended phase 1 rests in green.
    expect_run("rest_g1", 1, COL_GRN, 48);

    // Max-green with phases 0 and 2 held.
    clear = 1'b1;
    step();
    check("clear_before_maxg", 8'h00, 4'b0000, 1'b0);
    clear   = 1'b0;
    bus.req = 4'b0101;
    expect_run("maxg_g0", 0, COL_GRN, 12);
    expect_run("maxg_y0", 0, COL_YEL, 3);
    expect_run("maxg_r",  0, COL_ALLRED, 2);
    expect_run("maxg_g2", 2, COL_GRN, 1);

    // Gap-out: req[1] for two cycles, req[3] held.
    clear   = 1'b1;
    bus.req = '0;
    step();
    clear   = 1'b0;
    bus.req = 4'b1010;
    expect_run("gap_g1a", 1, COL_GRN, 1);
    bus.req = 4'b1000;
    expect_run("gap_g1b", 1, COL_GRN, 3);
    expect_run("gap_y1",  1, COL_YEL, 3);
    expect_run("gap_r",   0, COL_ALLRED, 2);
    expect_run("gap_g3",  3, COL_GRN, 1);

    // Fairness with everything held, then clear mid-yellow.
    clear   = 1'b1;
    bus.req = '0;
    step();
    clear   = 1'b0;
    bus.req = 4'b1111;
    for (int p = 0; p < N; p++) begin
      expect_run($sformatf("fair_g%0d", p), p, COL_GRN, 12);
      expect_run($sformatf("fair_y%0d", p), p, COL_YEL, 3);
      expect_run($sformatf("fair_r%0d", p), 0, COL_ALLRED, 2);
    end
    expect_run("fair_g0_again", 0, COL_GRN, 12);
    expect_run("fair_y0_again", 0, COL_YEL, 1);
    clear = 1'b1;
    expect_run("clear_mid_yel", 0, COL_IDLE, 1);
    clear   = 1'b0;
    bus.req = '0;
    expect_run("idle_after_clear", 0, COL_IDLE, 3);

    // One-cycle pulse held in pending; req at the ALLRED exit edge joins selection.
    bus.req = 4'b0001;
    expect_run("pulse_g0a", 0, COL_GRN, 1);
    bus.req = 4'b0000;
    expect_run("pulse_g0b", 0, COL_GRN, 5);
    bus.req = 4'b0100;
    expect_run("pulse_g0c", 0, COL_GRN, 1);
    bus.req = 4'b0000;
    expect_run("pulse_y0",  0, COL_YEL, 3);
    expect_run("pulse_r0",  0, COL_ALLRED, 2);
    bus.req = 4'b0010;
    expect_run("exit_g1a",  1, COL_GRN, 1);
    bus.req = 4'b0000;
    expect_run("exit_g1b",  1, COL_GRN, 3);
    expect_run("exit_y1",   1, COL_YEL, 3);
    expect_run("exit_r1",   0, COL_ALLRED, 2);
    expect_run("held_g2",   2, COL_GRN, 1);

`ifdef PREEMPT_EN
    clear = 1'b1;
    step();
    clear   = 1'b0;
    bus.req = 4'b0100;
    expect_run("pre_g2", 2, COL_GRN, 2);
    bus.preempt = 1'b1;
    expect_run("pre_y2", 2, COL_YEL, 3);
    expect_run("pre_r",  0, COL_ALLRED, 2);
    expect_run("pre_g0", 0, COL_GRN, 16);
    bus.preempt = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/intersection_phase_sched.md
# intersection_phase_sched

Round-robin phase scheduler for a multi-approach signalised intersection. It latches vehicle-sensor requests from NREQ approaches and grants the green to one approach at a time. Each grant is sequenced through timed GREEN, YELLOW and all-RED clearance intervals, with min-green and max-green limits. It drives one 2-bit signal head per approach using the codebase colour encoding RED=0, YELLOW=1, GREEN=2, and sits above the per-approach lamp drivers.

## Interface
Parameters:
- NREQ, 4: number of approaches/phases (2..8)
- MIN_G, 4: minimum green, cycles
- MAX_G, 12: maximum green when another approach is waiting, cycles
- Y_T, 3: yellow interval, cycles
- R_T, 2: all-red clearance, cycles
- CW, 4: timer width; requires MAX_G, Y_T, R_T < 2^CW
- PREEMPT_PHASE, 0: phase forced by preemption (only with PREEMPT_EN)

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- req  in  NREQ  sensor per approach, 1 = vehicle waiting
- preempt  in  1  emergency preemption request (only with PREEMPT_EN)
- sig  out  2*NREQ  head colour, approach i at sig[2i+1:2i]
- active  out  NREQ  one-hot approach currently GREEN or YELLOW, else 0
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE (all RED), GREEN, YELLOW, ALLRED. The state, timer, pending, last pointer and all outputs are registered.
- Reset (clear high at an edge): state IDLE, sig all RED (0), active=0, busy=0, pending=0, timer=0, last=NREQ-1. clear overrides all other inputs, including mid-interval.
- pending[i] is set by req[i] at every edge. The exception is i = the granted phase while in GREEN; its pending bit is neither set nor held.
- Grant selection: over (pending|req), search (last+1) mod NREQ upward with wrap; the first set bit wins and becomes last.
- IDLE: if (pending|req) is nonzero, go to GREEN for the winner, clear its pending bit and load timer=1. Otherwise stay in IDLE.
- GREEN: the timer increments and saturates at MAX_G. Define others = pending bits of the non-active phases.
  - timer < MIN_G: stay.
  - others = 0: stay indefinitely (rest in green), regardless of own req.
  - others ≠ 0 and (req[active]=0 or timer==MAX_G): go to YELLOW, timer=1.
- YELLOW: after exactly Y_T cycles go to ALLRED. active stays set; that head shows 1.
- ALLRED: active=0, all heads RED. After exactly R_T cycles, grant the next winner directly to GREEN, or go to IDLE if nothing is pending.
- Non-active heads are always RED. At most one head is non-RED at any time.

## Timing
- Request to green: 1 edge from IDLE. req high in cycle k gives GREEN in cycle k+1.
- Green lasts at least MIN_G cycles and at most MAX_G cycles when contended. It is unbounded when uncontended.
- YELLOW is exactly Y_T cycles and ALLRED is exactly R_T cycles.
- A request pulse of 1 cycle is never lost: it is held in pending until served, or until clear.
- A req at the same edge as the ALLRED exit is included in that selection.

## Configuration
- PREEMPT_EN defined:
  - preempt port exists.
  - While preempt=1: GREEN on PREEMPT_PHASE holds and ignores others. GREEN on another phase goes to YELLOW at the next edge, ignoring MIN_G.
  - YELLOW and ALLRED complete normally. The next grant, from ALLRED or IDLE, is PREEMPT_PHASE regardless of req or the round-robin pointer.
  - last is set to PREEMPT_PHASE.
- PREEMPT_EN undefined: the port is absent, with no preemption logic. Behaviour is exactly as above.

## Test plan
- Reset: clear high 2 cycles with req=4'b1111 → sig=0, active=0, busy=0. After release, phase 0 is GREEN 1 cycle later.
- Single 1-cycle pulse req[1] from IDLE → sig[3:2]=2 next cycle, active=4'b0010. It rests green for 50 cycles with no other req.
- req[0] and req[2] held → phase 0 GREEN 12 cycles, YELLOW 3, all RED 2, then phase 2 GREEN.
- Gap-out: req[1] high 2 cycles then low, req[3] held → phase 1 GREEN exactly 4 cycles, then YELLOW 3, ALLRED 2, then phase 3 GREEN.
- Fairness: all req held → green order 0,1,2,3,0, each green 12 cycles. clear asserted mid-YELLOW → IDLE, all RED and pending=0 on the next cycle.
- PREEMPT_EN: phase 2 GREEN at timer=2 with preempt=1 → YELLOW next cycle, then ALLRED 2, then phase 0 GREEN held while preempt=1.
